// File: rtl/eeprom_i2c_ctrl.sv
// I2C master for a 24C16-style EEPROM: single-byte write and random read.
// Each bus slot is four quarters of CLK_DIV clocks; SCL/SDA are registered outputs.
`timescale 1ns/1ps
module eeprom_i2c_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int TWR_CYCLES = 64,
  parameter int CHECK_ACK  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [10:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        ack_err,
  output logic        scl,
  inout  wire         sda
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_CTRL_W, S_ACK1, S_ADDR, S_ACK2, S_DATA_W, S_ACK3,
    S_RSTART, S_CTRL_R, S_ACK4, S_DATA_R, S_MNACK, S_STOP, S_WAIT_WR, S_DONE
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] TWR_LAST = 16'(TWR_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] wait_q, wait_d;
  logic        nack_q, nack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_oe_q, sda_oe_d;
  logic        sda_out_q, sda_out_d;

  logic        rw_q, rw_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        smp_q, smp_d;

  logic sda_in;
  logic slot_end;
  logic sample_pt;
  logic in_slot;
  logic scl_mid;
  logic ack_fail;

  assign sda_in    = sda;
  assign sda       = sda_oe_q ? sda_out_q : 1'bz;
  assign scl       = scl_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign rdata     = rdata_q;
  assign ack_err   = ack_err_q;

  assign slot_end  = (div_q == DIV_LAST) && (qtr_q == 2'd3);
  assign sample_pt = (div_q == 8'd0) && (qtr_q == 2'd2);
  assign in_slot   = (state_q != S_IDLE) && (state_q != S_WAIT_WR) && (state_q != S_DONE);
  assign scl_mid   = (qtr_q == 2'd1) || (qtr_q == 2'd2);
  assign ack_fail  = (CHECK_ACK != 0) && smp_q;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    nack_d    = nack_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    smp_d     = smp_q;
    scl_d     = 1'b1;
    sda_oe_d  = 1'b0;
    sda_out_d = 1'b1;

    if (in_slot) begin
      if (div_q == DIV_LAST) begin
        div_d = 8'd0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
      if (sample_pt) begin
        smp_d = sda_in;
      end
    end

    // Pin levels for the current slot and quarter
    unique case (state_q)
      S_START, S_RSTART: begin
        scl_d     = (qtr_q != 2'd3);
        sda_oe_d  = 1'b1;
        sda_out_d = ~qtr_q[1];
      end
      S_CTRL_W, S_ADDR, S_DATA_W, S_CTRL_R: begin
        scl_d     = scl_mid;
        sda_oe_d  = 1'b1;
        sda_out_d = tx_q[7];
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4, S_DATA_R: begin
        scl_d     = scl_mid;
      end
      S_MNACK: begin
        scl_d     = scl_mid;
        sda_oe_d  = 1'b1;
        sda_out_d = 1'b1;
      end
      S_STOP: begin
        scl_d     = (qtr_q != 2'd0);
        sda_oe_d  = (qtr_q != 2'd3);
        sda_out_d = qtr_q[1];
      end
      default: begin
        scl_d     = 1'b1;
      end
    endcase

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          rw_d      = rw;
          addr_d    = addr;
          wdata_d   = wdata;
          ack_err_d = 1'b0;
          nack_d    = 1'b0;
          div_d     = 8'd0;
          qtr_d     = 2'd0;
          bit_d     = 3'd0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (slot_end) begin
          tx_d    = {4'b1010, addr_q[10:8], 1'b0};
          state_d = S_CTRL_W;
        end
      end
      S_RSTART: begin
        if (slot_end) begin
          tx_d    = {4'b1010, addr_q[10:8], 1'b1};
          state_d = S_CTRL_R;
        end
      end
      S_CTRL_W, S_ADDR, S_DATA_W, S_CTRL_R: begin
        if (slot_end) begin
          tx_d = {tx_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
            unique case (state_q)
              S_CTRL_W: state_d = S_ACK1;
              S_ADDR:   state_d = S_ACK2;
              S_DATA_W: state_d = S_ACK3;
              default:  state_d = S_ACK4;
            endcase
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_ACK1, S_ACK2, S_ACK3, S_ACK4: begin
        if (slot_end) begin
          if (ack_fail) begin
            ack_err_d = 1'b1;
            nack_d    = 1'b1;
            state_d   = S_STOP;
          end else begin
            unique case (state_q)
              S_ACK1: begin
                tx_d    = addr_q[7:0];
                state_d = S_ADDR;
              end
              S_ACK2: begin
                tx_d    = wdata_q;
                state_d = rw_q ? S_RSTART : S_DATA_W;
              end
              S_ACK3:  state_d = S_STOP;
              default: state_d = S_DATA_R;
            endcase
          end
        end
      end
      S_DATA_R: begin
        if (sample_pt) begin
          rx_d = {rx_q[6:0], sda_in};
        end
        if (slot_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = S_MNACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_MNACK: begin
        if (slot_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (slot_end) begin
          if (!rw_q && !nack_q) begin
            wait_d  = 16'd0;
            state_d = S_WAIT_WR;
          end else begin
            if (rw_q && !nack_q) begin
              rdata_d = rx_q;
            end
            state_d = S_DONE;
          end
        end
      end
      // Bus stays idle while the EEPROM commits the byte internally
      S_WAIT_WR: begin
        if (wait_q == TWR_LAST) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      div_q     <= 8'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      wait_q    <= 16'd0;
      nack_q    <= 1'b0;
      rdata_q   <= 8'd0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      sda_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      nack_q    <= nack_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      sda_out_q <= sda_out_d;
    end
  end

  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    tx_q    <= tx_d;
    rx_q    <= rx_d;
    smp_q   <= smp_d;
  end

endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// Bench for eeprom_i2c_ctrl: a behavioural 24C16 slave on one bus, a slave-less
// bus for the ACK-checking variant, and done-driven scoreboards.
`timescale 1ns/1ps
module tb_eeprom_i2c_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, rw = 1'b0;
  logic [10:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, ack_err, scl;
  logic [7:0]  rdata;
  wire         sda;

  logic        req2 = 1'b0, rw2 = 1'b0;
  logic [10:0] addr2 = '0;
  logic [7:0]  wdata2 = '0;
  logic        busy2, done2, ack_err2, scl2;
  logic [7:0]  rdata2;
  wire         sda2;

  pullup (sda);
  pullup (sda2);

  always #5 clk = ~clk;

  eeprom_i2c_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  eeprom_i2c_ctrl #(.CLK_DIV(4), .TWR_CYCLES(64), .CHECK_ACK(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .rw(rw2), .addr(addr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .ack_err(ack_err2), .scl(scl2), .sda(sda2)
  );

  typedef struct {
    logic [7:0] rd;
    logic       ae;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       q1[$];
  exp_t       q2[$];
  logic [7:0] bq[$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         dn1 = 0;
  int         dn2 = 0;
  int         last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Behavioural EEPROM slave; also checks every byte framed on the bus
  logic [7:0] mem [0:2047];
  logic       s_drive = 1'b0;
  assign sda = s_drive ? 1'b0 : 1'bz;

  initial begin
    logic       pscl, psda, cs, cd;
    logic [7:0] sh, txb, word;
    logic [2:0] blk;
    int         bc, phase;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h07F] = 8'hC3;
    mem[11'h7FF] = 8'h55;
    pscl = 1'b1; psda = 1'b1; bc = 0; phase = 4;
    sh = 8'h00; txb = 8'h00; word = 8'h00; blk = 3'd0;
    forever begin
      @(posedge clk);
      cs = scl;
      cd = sda;
      if (pscl && cs && psda && !cd) begin
        bc = 0; phase = 0; s_drive = 1'b0;
      end else if (pscl && cs && !psda && cd) begin
        bc = 0; phase = 4; s_drive = 1'b0;
      end else if (!pscl && cs) begin
        if (bc < 8) begin
          sh = {sh[6:0], cd};
          bc++;
        end else if (bc == 8) begin
          if (phase == 3 && cd) phase = 4;
          bc = 9;
        end
      end else if (pscl && !cs) begin
        if (bc == 8) begin
          if (bq.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL bus_byte: got %0h, expected no byte (cycle %0d)", sh, cyc);
          end else begin
            chk("bus_byte", {24'd0, sh}, {24'd0, bq.pop_front()});
          end
          case (phase)
            0: begin
              if (sh[7:4] == 4'hA) begin
                blk = sh[3:1];
                phase = sh[0] ? 3 : 1;
                s_drive = 1'b1;
              end else begin
                phase = 4;
              end
            end
            1: begin word = sh; phase = 2; s_drive = 1'b1; end
            2: begin mem[{blk, word}] = sh; word = word + 8'd1; s_drive = 1'b1; end
            default: s_drive = 1'b0;
          endcase
        end else if (bc == 9) begin
          bc = 0;
          if (phase == 3) begin
            txb = mem[{blk, word}];
            s_drive = ~txb[7];
          end else begin
            s_drive = 1'b0;
          end
        end else if (phase == 3 && bc >= 1 && bc <= 7) begin
          s_drive = ~txb[7 - bc];
        end
      end
      pscl = cs;
      psda = cd;
    end
  end

  // Scoreboard monitors: compare whenever a controller presents done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        dn1++;
        if (q1.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL done1: got unexpected done pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = q1.pop_front();
          chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
          chk("ack_err", {31'd0, ack_err}, {31'd0, e.ae});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("latency", cyc - e.acc, e.lat);
        end
      end
      if (done2) begin
        dn2++;
        if (q2.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL done2: got unexpected done pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = q2.pop_front();
          chk("rdata2", {24'd0, rdata2}, {24'd0, e.rd});
          chk("ack_err2", {31'd0, ack_err2}, {31'd0, e.ae});
          chk("latency2", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue1(input logic r, input logic [10:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd, input int lat);
    exp_t e;
    step();
    req = 1'b1; rw = r; addr = a; wdata = d;
    e.rd = exp_rd; e.ae = 1'b0; e.lat = lat; e.acc = cyc + 1;
    last_acc = e.acc;
    q1.push_back(e);
    step();
    req = 1'b0;
  endtask

  task automatic issue2(input logic r, input logic [10:0] a, input logic [7:0] d);
    exp_t e;
    step();
    req2 = 1'b1; rw2 = r; addr2 = a; wdata2 = d;
    e.rd = 8'h00; e.ae = 1'b1; e.lat = 176; e.acc = cyc + 1;
    q2.push_back(e);
    step();
    req2 = 1'b0;
  endtask

  task automatic wait_done1();
    int start = dn1;
    for (int i = 0; i < 1500 && dn1 == start; i++) step();
    chk("done1_seen", {31'd0, (dn1 != start)}, 32'd1);
  endtask

  task automatic wait_done2();
    int start = dn2;
    for (int i = 0; i < 1500 && dn2 == start; i++) step();
    chk("done2_seen", {31'd0, (dn2 != start)}, 32'd1);
  endtask

  task automatic bus3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    bq.push_back(b0); bq.push_back(b1); bq.push_back(b2);
  endtask

  task automatic bus4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    bq.push_back(b0); bq.push_back(b1); bq.push_back(b2); bq.push_back(b3);
  endtask

  initial begin
    logic ok;
    repeat (5) step();
    rst_n = 1'b1;
    step();
    chk("rst_scl", {31'd0, scl}, 32'd1);
    chk("rst_sda", {31'd0, (sda === 1'b1)}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_ack_err", {31'd0, ack_err}, 32'd0);

    // ACK-checking controller with nothing but the pull-up on its bus
    issue2(1'b0, 11'h3A5, 8'h5C);
    chk("busy2_after_accept", {31'd0, busy2}, 32'd1);
    wait_done2();
    issue2(1'b1, 11'h07F, 8'h00);
    wait_done2();

    bus3(8'hA6, 8'hA5, 8'h5C);
    issue1(1'b0, 11'h3A5, 8'h5C, 8'h00, 528);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_done1();

    bus4(8'hA0, 8'h7F, 8'hA1, 8'hC3);
    issue1(1'b1, 11'h07F, 8'h00, 8'hC3, 624);
    wait_done1();

    // A request while busy must be dropped
    bus3(8'hA2, 8'h23, 8'h9A);
    issue1(1'b0, 11'h123, 8'h9A, 8'hC3, 528);
    while (cyc < last_acc + 100) step();
    req = 1'b1; rw = 1'b0; addr = 11'h456; wdata = 8'h11;
    step();
    req = 1'b0;
    wait_done1();
    repeat (20) step();

    // Reset in the middle of the address byte
    bq.push_back(8'hA4);
    issue1(1'b0, 11'h2B0, 8'h77, 8'hC3, 528);
    while (cyc < last_acc + 200) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    q1.delete();
    chk("midrst_scl", {31'd0, scl}, 32'd1);
    chk("midrst_sda", {31'd0, (sda === 1'b1)}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_bus_q", bq.size(), 32'd0);
    repeat (40) step();

    bus3(8'hA4, 8'hB0, 8'h78);
    issue1(1'b0, 11'h2B0, 8'h78, 8'h00, 528);
    wait_done1();

    // Back-to-back write then read, bus idle during the write-cycle wait
    bus3(8'hAE, 8'hFF, 8'h00);
    issue1(1'b0, 11'h7FF, 8'h00, 8'h00, 528);
    while (cyc < last_acc + 470) step();
    ok = 1'b1;
    repeat (50) begin
      if (!(scl === 1'b1 && sda === 1'b1)) ok = 1'b0;
      step();
    end
    chk("wait_wr_idle", {31'd0, ok}, 32'd1);
    wait_done1();
    bus4(8'hAE, 8'hFF, 8'hAF, 8'h00);
    issue1(1'b1, 11'h7FF, 8'h00, 8'h00, 624);
    wait_done1();
    repeat (20) step();

    chk("mem_3A5", {24'd0, mem[11'h3A5]}, 32'h5C);
    chk("mem_123", {24'd0, mem[11'h123]}, 32'h9A);
    chk("mem_456", {24'd0, mem[11'h456]}, 32'h00);
    chk("mem_2B0", {24'd0, mem[11'h2B0]}, 32'h78);
    chk("mem_7FF", {24'd0, mem[11'h7FF]}, 32'h00);
    chk("done1_count", dn1, 32'd6);
    chk("done2_count", dn2, 32'd2);
    chk("sb1_left", q1.size(), 32'd0);
    chk("sb2_left", q2.size(), 32'd0);
    chk("bus_q_left", bq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
